// File: rtl/mem_read_sched_pkg.sv
// Shared types, constants and select-code lookup for the per-BX read scheduler.
// Latency: none (declarations and a pure combinational function only).
// Backpressure: none; the scheduler is open-loop and has no ready input.
package mem_read_sched_pkg;

  localparam int NPORT = 12;
  localparam int AW    = 6;

  localparam logic [3:0] HDR_CODE  = 4'b1111;
  localparam logic [3:0] IDLE_CODE = 4'b0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    READ   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Ports 9..11 skip 4'b1010 so the downstream mux never sees that code;
  // 4'b1110 is likewise left unused.
  function automatic logic [3:0] port_code(input logic [3:0] p);
    logic [3:0] code;
    case (p)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8: code = p + 4'd1;
      4'd9:                   code = 4'b1011;
      4'd10:                  code = 4'b1100;
      4'd11:                  code = 4'b1101;
      default:                code = IDLE_CODE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_read_sched_prio_enc12.sv
// Lowest-index-set priority encoder over the 12 "port still has entries" bits.
// Latency: purely combinational.
// Backpressure: none.
module prio_enc12
  import mem_read_sched_pkg::*;
(
  input  logic [NPORT-1:0] req,
  output logic [3:0]       index,
  output logic             any
);

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    index = 4'd0;
    any   = 1'b0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (req[k]) begin
        index = 4'(k);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_read_sched.sv
// Per-BX read scheduler: header slot, then one read slot per stored entry, ports ascending.
// Latency: header one cycle after start, first data slot two cycles after start; all outputs registered.
// Backpressure: none; slots issue every cycle, a per-frame budget caps the frame and flags truncation.
module mem_read_sched
  import mem_read_sched_pkg::*;
#(
  parameter int BUDGET = 100
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [2:0]          bx_in,
  input  logic [NPORT*AW-1:0] nent,
  output logic [3:0]          sel,
  output logic [2:0]          bx_out,
  output logic [NPORT-1:0]    rd_en,
  output logic [AW-1:0]       rd_addr,
  output logic                busy,
  output logic                done,
  output logic                trunc
);

  localparam int SW = $clog2(BUDGET + 1);

  state_t           state, state_n;
  logic [AW-1:0]    rem     [NPORT];
  logic [AW-1:0]    rem_n   [NPORT];
  logic [AW-1:0]    lat     [NPORT];
  logic [AW-1:0]    lat_n   [NPORT];
  logic [SW-1:0]    slot, slot_n;

  logic [3:0]       sel_n;
  logic [2:0]       bx_n;
  logic [NPORT-1:0] rd_en_n;
  logic [AW-1:0]    rd_addr_n;
  logic             busy_n, done_n, trunc_n;

  logic [NPORT-1:0] nz;
  logic [3:0]       idx;
  logic             any;

  // A port is a candidate while it still has unread entries.
  always_comb begin
    for (int k = 0; k < NPORT; k++) nz[k] = (rem[k] != '0);
  end

  prio_enc12 u_prio (
    .req   (nz),
    .index (idx),
    .any   (any)
  );

  // Next state and next registered outputs; the registered copy of each is
  // what the downstream mux sees, so rem already excludes the displayed slot.
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    lat_n     = lat;
    slot_n    = slot;
    sel_n     = IDLE_CODE;
    bx_n      = bx_out;
    rd_en_n   = '0;
    rd_addr_n = '0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    trunc_n   = trunc;

    if (start) begin
      // A start always opens a new frame; an aborted frame reports its
      // leftovers through trunc during the new header only.
      state_n = HEADER;
      sel_n   = HDR_CODE;
      bx_n    = bx_in;
      busy_n  = 1'b1;
      slot_n  = SW'(1);
      trunc_n = busy && any;
      for (int k = 0; k < NPORT; k++) begin
        rem_n[k] = nent[k*AW +: AW];
        lat_n[k] = nent[k*AW +: AW];
      end
    end else begin
      case (state)
        HEADER, READ: begin
          if (!any || slot >= SW'(BUDGET)) begin
            state_n = DONE;
            done_n  = 1'b1;
            trunc_n = any;
          end else begin
            state_n    = READ;
            busy_n     = 1'b1;
            sel_n      = port_code(idx);
            rd_en_n    = {{(NPORT-1){1'b0}}, 1'b1} << idx;
            rd_addr_n  = lat[idx] - rem[idx];
            rem_n[idx] = rem[idx] - AW'(1);
            slot_n     = slot + SW'(1);
            trunc_n    = 1'b0;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State, per-port counters and all outputs update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      slot    <= '0;
      sel     <= IDLE_CODE;
      bx_out  <= '0;
      rd_en   <= '0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      trunc   <= 1'b0;
      for (int k = 0; k < NPORT; k++) begin
        rem[k] <= '0;
        lat[k] <= '0;
      end
    end else begin
      state   <= state_n;
      slot    <= slot_n;
      sel     <= sel_n;
      bx_out  <= bx_n;
      rd_en   <= rd_en_n;
      rd_addr <= rd_addr_n;
      busy    <= busy_n;
      done    <= done_n;
      trunc   <= trunc_n;
      for (int k = 0; k < NPORT; k++) begin
        rem[k] <= rem_n[k];
        lat[k] <= lat_n[k];
      end
    end
  end

endmodule

// File: tb/tb_mem_read_sched.sv
// Directed bench for mem_read_sched with hand-computed expected slot sequences.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: not applicable.
module tb_mem_read_sched;
  import mem_read_sched_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [2:0]          bx_in = '0;
  logic [NPORT*AW-1:0] nent = '0;
  logic [3:0]          sel;
  logic [2:0]          bx_out;
  logic [NPORT-1:0]    rd_en;
  logic [AW-1:0]       rd_addr;
  logic                busy, done, trunc;

  int n_checks = 0;
  int n_errors = 0;
  int bad_codes = 0;

  mem_read_sched #(.BUDGET(100)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bx_in   (bx_in),
    .nent    (nent),
    .sel     (sel),
    .bx_out  (bx_out),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .busy    (busy),
    .done    (done),
    .trunc   (trunc)
  );

  always #5 clk = ~clk;

  // Reserved select codes must never appear on the mux.
  always @(negedge clk) begin
    if (sel == 4'b1010 || sel == 4'b1110) bad_codes++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle start; returns sampling the HEADER cycle.
  task automatic start_frame(input logic [2:0] bx, input logic [NPORT*AW-1:0] cnt);
    start = 1'b1;
    bx_in = bx;
    nent  = cnt;
    tick();
    start = 1'b0;
    nent  = '0;
  endtask

  task automatic expect_slot(input string tag, input logic [3:0] code, input int port, input int addr);
    check({tag, "_sel"},  32'(sel), 32'(code));
    check({tag, "_rden"}, 32'(rd_en), 32'(1) << port);
    check({tag, "_addr"}, 32'(rd_addr), 32'(addr));
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic expect_header(input string tag, input logic [2:0] bx, input logic tr);
    check({tag, "_hsel"},  32'(sel), 32'hF);
    check({tag, "_hbx"},   32'(bx_out), 32'(bx));
    check({tag, "_hbusy"}, 32'(busy), 32'd1);
    check({tag, "_hrden"}, 32'(rd_en), 32'd0);
    check({tag, "_htrunc"}, 32'(trunc), 32'(tr));
  endtask

  task automatic expect_done(input string tag, input logic tr);
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_dsel"},  32'(sel), 32'd0);
    check({tag, "_dbusy"}, 32'(busy), 32'd0);
    check({tag, "_drden"}, 32'(rd_en), 32'd0);
    check({tag, "_dtrunc"}, 32'(trunc), 32'(tr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NPORT*AW-1:0] v;
    logic [3:0] hi_codes [3];
    hi_codes[0] = 4'b1011;
    hi_codes[1] = 4'b1100;
    hi_codes[2] = 4'b1101;

    // Reset state.
    repeat (3) tick();
    check("rst_sel",   32'(sel), 32'd0);
    check("rst_rden",  32'(rd_en), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_trunc", 32'(trunc), 32'd0);
    check("rst_bx",    32'(bx_out), 32'd0);
    reset_n = 1'b1;
    repeat (5) tick();
    check("idle_sel",  32'(sel), 32'd0);
    check("idle_rden", 32'(rd_en), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Port 2 has two entries, port 9 one.
    v = '0;
    v[2*AW +: AW] = 6'd2;
    v[9*AW +: AW] = 6'd1;
    start_frame(3'd5, v);
    expect_header("a", 3'd5, 1'b0);
    tick(); expect_slot("a0", 4'b0011, 2, 0);
    tick(); expect_slot("a1", 4'b0011, 2, 1);
    tick(); expect_slot("a2", 4'b1011, 9, 0);
    tick(); expect_done("a", 1'b0);
    check("a_bxhold", 32'(bx_out), 32'd5);
    tick();
    check("a_done_clr", 32'(done), 32'd0);
    check("a_bx_idle",  32'(bx_out), 32'd5);

    // Empty frame: header then done, no read.
    start_frame(3'd2, '0);
    expect_header("z", 3'd2, 1'b0);
    tick(); expect_done("z", 1'b0);
    tick();
    check("z_idle_rden", 32'(rd_en), 32'd0);

    // Budget: 1 header + 99 reads, port 11 truncated after address 35.
    v = '0;
    v[0*AW +: AW]  = 6'd63;
    v[11*AW +: AW] = 6'd63;
    start_frame(3'd7, v);
    expect_header("b", 3'd7, 1'b0);
    for (int i = 0; i < 63; i++) begin
      tick(); expect_slot("b_p0", 4'b0001, 0, i);
    end
    for (int i = 0; i < 36; i++) begin
      tick(); expect_slot("b_p11", 4'b1101, 11, i);
    end
    tick(); expect_done("b", 1'b1);
    tick();
    check("b_trunc_hold", 32'(trunc), 32'd1);
    check("b_done_clr",   32'(done), 32'd0);

    // Abort: new start during the third read of a 10-entry frame.
    v = '0;
    v[0*AW +: AW] = 6'd10;
    start_frame(3'd1, v);
    expect_header("c", 3'd1, 1'b0);
    tick(); expect_slot("c0", 4'b0001, 0, 0);
    tick(); expect_slot("c1", 4'b0001, 0, 1);
    tick(); expect_slot("c2", 4'b0001, 0, 2);
    v = '0;
    v[1*AW +: AW] = 6'd2;
    start_frame(3'd6, v);
    check("c_nodone", 32'(done), 32'd0);
    expect_header("c_new", 3'd6, 1'b1);
    tick(); expect_slot("c_n0", 4'b0010, 1, 0);
    check("c_trunc_clr", 32'(trunc), 32'd0);
    tick(); expect_slot("c_n1", 4'b0010, 1, 1);
    tick(); expect_done("c_new", 1'b0);

    // Ports 9, 10, 11 each alone.
    for (int j = 0; j < 3; j++) begin
      v = '0;
      v[(9+j)*AW +: AW] = 6'd1;
      start_frame(3'(j), v);
      expect_header("h", 3'(j), 1'b0);
      tick(); expect_slot("h_slot", hi_codes[j], 9 + j, 0);
      tick(); expect_done("h", 1'b0);
      tick();
    end

    // Start during the DONE cycle: done still pulses, header follows.
    v = '0;
    v[0*AW +: AW] = 6'd1;
    start_frame(3'd3, v);
    tick(); expect_slot("d0", 4'b0001, 0, 0);
    tick();
    check("d_done", 32'(done), 32'd1);
    v = '0;
    v[3*AW +: AW] = 6'd1;
    start_frame(3'd4, v);
    expect_header("d_new", 3'd4, 1'b0);
    tick(); expect_slot("d_n0", 4'b0100, 3, 0);
    tick(); expect_done("d_new", 1'b0);
    tick();

    // Asynchronous reset mid-frame.
    v = '0;
    v[0*AW +: AW] = 6'd20;
    start_frame(3'd6, v);
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    check("mr_sel",   32'(sel), 32'd0);
    check("mr_rden",  32'(rd_en), 32'd0);
    check("mr_addr",  32'(rd_addr), 32'd0);
    check("mr_busy",  32'(busy), 32'd0);
    check("mr_done",  32'(done), 32'd0);
    check("mr_bx",    32'(bx_out), 32'd0);
    check("mr_trunc", 32'(trunc), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("mr_nodone", 32'(done), 32'd0);
    check("mr_idle",   32'(busy), 32'd0);

    check("bad_codes", 32'(bad_codes), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
